// File: rtl/design_switch_ctrl.sv
// Safe run-time design selector: debounces a new selection, then walks the
// design set through pads-safe quiesce, select change and reset hold.
module design_switch_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 16,
    parameter int QUIESCE_CYCLES = 8,
    parameter int RESET_CYCLES   = 32
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [2:0] sel_raw,
    input  logic       ext_rst_n,
    output logic [2:0] design_sel,
    output logic       rst_override_n,
    output logic       pads_safe,
    output logic       busy,
    output logic [7:0] switch_count
);

    localparam int MAX_SQ  = (STABLE_CYCLES > QUIESCE_CYCLES) ? STABLE_CYCLES : QUIESCE_CYCLES;
    localparam int MAX_CYC = (MAX_SQ > RESET_CYCLES) ? MAX_SQ : RESET_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] QUIESCE_LOAD = CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD   = CNT_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        STABLE  = 3'd1,
        QUIESCE = 3'd2,
        SWITCH  = 3'd3,
        HOLD    = 3'd4
    } state_t;

    logic [SYNC_STAGES*3-1:0] sel_sync_q, sel_sync_d;
    logic [SYNC_STAGES-1:0]   ext_sync_q, ext_sync_d;
    logic [2:0]               sel_s;
    logic                     ext_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cand_q, cand_d;
    logic [2:0]       design_sel_q, design_sel_d;
    logic [7:0]       switch_count_q, switch_count_d;
    logic             rst_override_n_q, rst_override_n_d;
    logic             pads_safe_q, pads_safe_d;
    logic             busy_q, busy_d;
    logic             run_like_s;

    // Synchronizer shift: newest sample enters at the low end.
    always_comb begin
        sel_sync_d = {sel_sync_q[(SYNC_STAGES-1)*3-1:0], sel_raw};
        ext_sync_d = {ext_sync_q[SYNC_STAGES-2:0], ext_rst_n};
    end

    assign sel_s = sel_sync_q[SYNC_STAGES*3-1 -: 3];
    assign ext_s = ext_sync_q[SYNC_STAGES-1];

    // Synchronizer flops.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sel_sync_q <= '0;
            ext_sync_q <= '0;
        end else begin
            sel_sync_q <= sel_sync_d;
            ext_sync_q <= ext_sync_d;
        end
    end

    // Next-state, shared down-counter and select/count update.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cand_d         = cand_q;
        design_sel_d   = design_sel_q;
        switch_count_d = switch_count_q;
        case (state_q)
            RUN: begin
                if (!ext_s) begin
                    state_d = HOLD;
                    cnt_d   = RESET_LOAD;
                end else if (sel_s != design_sel_q) begin
                    state_d = STABLE;
                    cand_d  = sel_s;
                    cnt_d   = STABLE_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            STABLE: begin
                if (!ext_s) begin
                    state_d = HOLD;
                    cnt_d   = RESET_LOAD;
                end else if (sel_s == design_sel_q) begin
                    state_d = RUN;
                end else if (sel_s != cand_q) begin
                    cand_d = sel_s;
                    cnt_d  = STABLE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = QUIESCE;
                    cnt_d   = QUIESCE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // External reset cannot abort a switch once quiescing has begun.
            QUIESCE: begin
                if (cnt_q == '0) begin
                    state_d = SWITCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SWITCH: begin
                state_d        = HOLD;
                cnt_d          = RESET_LOAD;
                design_sel_d   = cand_q;
                switch_count_d = switch_count_q + 8'd1;
            end
            HOLD: begin
                if (!ext_s) begin
                    cnt_d = RESET_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = RESET_LOAD;
            end
        endcase
    end

    // Outputs decoded from the next state so the flops line up with state_q.
    always_comb begin
        run_like_s       = (state_d == RUN) || (state_d == STABLE);
        rst_override_n_d = run_like_s;
        pads_safe_d      = !run_like_s;
        busy_d           = (state_d != RUN);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= HOLD;
            cnt_q            <= RESET_LOAD;
            cand_q           <= 3'd0;
            design_sel_q     <= 3'd0;
            switch_count_q   <= 8'd0;
            rst_override_n_q <= 1'b0;
            pads_safe_q      <= 1'b1;
            busy_q           <= 1'b1;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cand_q           <= cand_d;
            design_sel_q     <= design_sel_d;
            switch_count_q   <= switch_count_d;
            rst_override_n_q <= rst_override_n_d;
            pads_safe_q      <= pads_safe_d;
            busy_q           <= busy_d;
        end
    end

    assign design_sel     = design_sel_q;
    assign switch_count   = switch_count_q;
    assign rst_override_n = rst_override_n_q;
    assign pads_safe      = pads_safe_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_design_switch_ctrl.sv
// Self-checking bench for design_switch_ctrl: scoreboard of expected
// {design_sel, switch_count} pairs popped whenever switch_count moves.
module tb_design_switch_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] sel_raw;
    logic       ext_rst_n;
    logic [2:0] design_sel;
    logic       rst_override_n;
    logic       pads_safe;
    logic       busy;
    logic [7:0] switch_count;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         errors;
    int         checks;
    logic [7:0] prev_count;
    logic [2:0] model_sel;
    logic [7:0] model_count;

    design_switch_ctrl dut (
        .clk_i         (clk),
        .rst_n         (rst_n),
        .sel_raw       (sel_raw),
        .ext_rst_n     (ext_rst_n),
        .design_sel    (design_sel),
        .rst_override_n(rst_override_n),
        .pads_safe     (pads_safe),
        .busy          (busy),
        .switch_count  (switch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample on the falling edge and service the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            prev_count = switch_count;
        end else if (switch_count !== prev_count) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got sel=%0d count=%0d, no switch expected",
                         design_sel, switch_count);
            end else begin
                e = exp_q.pop_front();
                if ({design_sel, switch_count} !== {e.sel, e.cnt}) begin
                    errors++;
                    $display("FAIL sb_switch: got sel=%0d count=%0d, want sel=%0d count=%0d",
                             design_sel, switch_count, e.sel, e.cnt);
                end
            end
            prev_count = switch_count;
        end
        checks++;
        if (rst_override_n === 1'b0 && pads_safe !== 1'b1) begin
            errors++;
            $display("FAIL pads_vs_rst: pads_safe=%0b while rst_override_n=0", pads_safe);
        end
    endtask

    task automatic push_switch(input logic [2:0] to);
        model_count = model_count + 8'd1;
        model_sel   = to;
        exp_q.push_back('{sel: to, cnt: model_count});
    endtask

    task automatic test_reset();
        int  n;
        bit  bad;
        rst_n     = 1'b1;
        ext_rst_n = 1'b1;
        sel_raw   = 3'd0;
        #1 rst_n  = 1'b0;
        #1;
        checks++;
        if ({design_sel, rst_override_n, pads_safe, busy, switch_count} !== {3'd0, 1'b0, 1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset_values: got sel=%0d rov=%0b ps=%0b busy=%0b cnt=%0d, want 0 0 1 1 0",
                     design_sel, rst_override_n, pads_safe, busy, switch_count);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        n   = 0;
        bad = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (design_sel !== 3'd0 || switch_count !== 8'd0) bad = 1'b1;
            if (rst_override_n === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n < 33 || n > 35) begin
            errors++;
            $display("FAIL powerup_latency: got %0d cycles, want 33..35", n);
        end
        checks++;
        if (busy !== 1'b0 || pads_safe !== 1'b0) begin
            errors++;
            $display("FAIL powerup_run: got busy=%0b pads_safe=%0b, want 0 0", busy, pads_safe);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL powerup_hold_values: design_sel/switch_count moved, want 0/0");
        end
    endtask

    task automatic test_switch(input logic [2:0] to);
        int t_sel;
        int low;
        t_sel = 0;
        low   = 0;
        push_switch(to);
        sel_raw = to;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (rst_override_n === 1'b0) low++;
            if (design_sel === to && t_sel == 0) t_sel = i;
            if (low > 0 && busy === 1'b0) break;
        end
        checks++;
        if (t_sel < 26 || t_sel > 29) begin
            errors++;
            $display("FAIL switch_latency: got %0d cycles, want 26..29", t_sel);
        end
        checks++;
        if (low != 41) begin
            errors++;
            $display("FAIL switch_rst_low: got %0d cycles, want 41", low);
        end
        checks++;
        if ({design_sel, switch_count, busy, pads_safe} !== {to, model_count, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL switch_final: got sel=%0d cnt=%0d busy=%0b ps=%0b, want sel=%0d cnt=%0d 0 0",
                     design_sel, switch_count, busy, pads_safe, to, model_count);
        end
    endtask

    task automatic test_glitch();
        int busy_n;
        int low;
        busy_n  = 0;
        low     = 0;
        sel_raw = 3'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy === 1'b1) busy_n++;
            if (rst_override_n === 1'b0) low++;
        end
        sel_raw = model_sel;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy === 1'b1) busy_n++;
            if (rst_override_n === 1'b0) low++;
        end
        checks++;
        if (busy_n < 9 || busy_n > 11) begin
            errors++;
            $display("FAIL glitch_busy: got %0d busy cycles, want 9..11", busy_n);
        end
        checks++;
        if (low != 0) begin
            errors++;
            $display("FAIL glitch_rst: got %0d low cycles, want 0", low);
        end
        checks++;
        if ({design_sel, switch_count} !== {model_sel, model_count}) begin
            errors++;
            $display("FAIL glitch_state: got sel=%0d cnt=%0d, want sel=%0d cnt=%0d",
                     design_sel, switch_count, model_sel, model_count);
        end
    endtask

    task automatic test_restart();
        int t_sel;
        int low;
        bit saw4;
        t_sel   = 0;
        low     = 0;
        saw4    = 1'b0;
        sel_raw = 3'd4;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (design_sel === 3'd4) saw4 = 1'b1;
        end
        push_switch(3'd6);
        sel_raw = 3'd6;
        for (int i = 13; i <= 160; i++) begin
            tick();
            if (design_sel === 3'd4) saw4 = 1'b1;
            if (rst_override_n === 1'b0) low++;
            if (design_sel === 3'd6 && t_sel == 0) t_sel = i;
            if (low > 0 && busy === 1'b0) break;
        end
        checks++;
        if (saw4) begin
            errors++;
            $display("FAIL restart_never4: design_sel took 4, want never");
        end
        checks++;
        if (t_sel < 39 || t_sel > 41) begin
            errors++;
            $display("FAIL restart_latency: got %0d cycles, want 39..41", t_sel);
        end
        checks++;
        if ({design_sel, switch_count} !== {3'd6, model_count}) begin
            errors++;
            $display("FAIL restart_final: got sel=%0d cnt=%0d, want sel=6 cnt=%0d",
                     design_sel, switch_count, model_count);
        end
    endtask

    task automatic test_ext_reset();
        int low;
        low       = 0;
        ext_rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rst_override_n === 1'b0) low++;
        end
        ext_rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (rst_override_n === 1'b0) low++;
            if (low > 0 && rst_override_n === 1'b1) break;
        end
        checks++;
        if (low < 50 || low > 52) begin
            errors++;
            $display("FAIL ext_rst_low: got %0d cycles, want 50..52", low);
        end
        checks++;
        if ({design_sel, switch_count, busy} !== {model_sel, model_count, 1'b0}) begin
            errors++;
            $display("FAIL ext_rst_state: got sel=%0d cnt=%0d busy=%0b, want sel=%0d cnt=%0d busy=0",
                     design_sel, switch_count, busy, model_sel, model_count);
        end
    endtask

    task automatic test_mid_reset();
        bit done;
        test_switch(3'd2);
        push_switch(3'd7);
        sel_raw = 3'd7;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (design_sel === 3'd7) break;
        end
        repeat (5) tick();
        checks++;
        if (rst_override_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_hold: got rst_override_n=%0b, want 0", rst_override_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({design_sel, switch_count, rst_override_n, pads_safe, busy} !== {3'd0, 8'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_async_reset: got sel=%0d cnt=%0d rov=%0b ps=%0b busy=%0b, want 0 0 0 1 1",
                     design_sel, switch_count, rst_override_n, pads_safe, busy);
        end
        model_sel   = 3'd0;
        model_count = 8'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        push_switch(3'd7);
        done = 1'b0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (design_sel === 3'd7 && busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done || {design_sel, switch_count, rst_override_n} !== {3'd7, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL mid_fresh_switch: got sel=%0d cnt=%0d rov=%0b done=%0b, want 7 1 1 1",
                     design_sel, switch_count, rst_override_n, done);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        prev_count  = 8'd0;
        model_sel   = 3'd0;
        model_count = 8'd0;
        test_reset();
        test_switch(3'd5);
        test_glitch();
        test_restart();
        test_ext_reset();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending switches, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
